barrelshifter16_driver: RTL and testbench

//  Initiator for the 16-bit barrel shifter command interface (peer: barrelshifter16).

---
 rtl/barrelshifter16_pkg.sv | 34 +++
 rtl/barrelshifter16_driver.sv | 129 ++++++++++++
 tb/tb_barrelshifter16_driver.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/barrelshifter16_pkg.sv
// Shared types, direction codes and rotate reference functions for the
// barrel shifter driver and its bench.
package barrelshifter16_pkg;

  localparam logic [1:0] BS_DIR_LEFT  = 2'b10;
  localparam logic [1:0] BS_DIR_RIGHT = 2'b01;

  typedef enum logic [2:0] {
    BS_IDLE    = 3'd0,
    BS_WRITE   = 3'd1,
    BS_EXEC    = 3'd2,
    BS_CAPTURE = 3'd3,
    BS_RESP    = 3'd4
  } bs_drv_state_t;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } bs_rsp_t;

  // Rotating the doubled word keeps both halves in range, so k=0 returns d.
  function automatic logic [15:0] rotl16(input logic [15:0] d, input logic [2:0] k);
    logic [31:0] t;
    t = {d, d} << k;
    return t[31:16];
  endfunction

  function automatic logic [15:0] rotr16(input logic [15:0] d, input logic [2:0] k);
    logic [31:0] t;
    t = {d, d} >> k;
    return t[15:0];
  endfunction

endpackage

// File: rtl/barrelshifter16_driver.sv
// Initiator for the barrelshifter16 peer: sequences enable/write/coeff pins per
// rotate request and returns the captured result on a valid/ready stream.
module barrelshifter16_driver
  import barrelshifter16_pkg::*;
#(
  parameter int unsigned WR_HOLD  = 3,
  parameter int unsigned EX_HOLD  = 2,
  parameter int unsigned CHECK_EN = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  input  logic [2:0]  s_amount,
  input  logic        s_left,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_err,
  output logic        bs_enable,
  output logic        bs_write,
  output logic [1:0]  bs_direction,
  output logic [15:0] bs_input,
  output logic [2:0]  bs_coeff,
  input  logic [15:0] bs_result,
  output logic        busy,
  output logic [15:0] txn_count
);

  localparam int unsigned CNT_W = 8;

  bs_drv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      exp_data;
  logic             chk_err;

  // Reference rotate is taken from the request regs that also drive the peer.
  always_comb begin
    exp_data = '0;
    if (bs_direction == BS_DIR_LEFT) begin
      exp_data = rotl16(bs_input, bs_coeff);
    end else begin
      exp_data = rotr16(bs_input, bs_coeff);
    end
    chk_err = (CHECK_EN != 0) && (bs_result != exp_data);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= BS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      BS_IDLE: begin
        if (s_valid) begin
          state_d = BS_WRITE;
          cnt_d   = CNT_W'(WR_HOLD - 1);
        end
      end
      BS_WRITE: begin
        if (cnt_q == '0) begin
          state_d = BS_EXEC;
          cnt_d   = CNT_W'(EX_HOLD - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BS_EXEC: begin
        if (cnt_q == '0) begin
          state_d = BS_CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BS_CAPTURE: state_d = BS_RESP;
      BS_RESP: begin
        if (m_ready) begin
          state_d = BS_IDLE;
        end
      end
      default: state_d = BS_IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they align with it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_ready      <= 1'b1;
      busy         <= 1'b0;
      m_valid      <= 1'b0;
      bs_enable    <= 1'b0;
      bs_write     <= 1'b0;
      bs_direction <= '0;
      bs_input     <= '0;
      bs_coeff     <= '0;
      m_data       <= '0;
      m_err        <= 1'b0;
      txn_count    <= '0;
    end else begin
      s_ready   <= (state_d == BS_IDLE);
      busy      <= (state_d != BS_IDLE);
      m_valid   <= (state_d == BS_RESP);
      bs_enable <= (state_d == BS_WRITE) || (state_d == BS_EXEC);
      bs_write  <= (state_d == BS_WRITE);
      if ((state_q == BS_IDLE) && s_valid) begin
        bs_input     <= s_data;
        bs_coeff     <= s_amount;
        bs_direction <= s_left ? BS_DIR_LEFT : BS_DIR_RIGHT;
      end
      if (state_q == BS_CAPTURE) begin
        m_data <= bs_result;
        m_err  <= chk_err;
      end
      if ((state_q == BS_RESP) && m_ready) begin
        txn_count <= txn_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_barrelshifter16_driver.sv
// Scoreboard bench for barrelshifter16_driver with a behavioural shifter peer.
module tb_barrelshifter16_driver;
  import barrelshifter16_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = '0;
  logic [2:0]  s_amount = '0;
  logic        s_left = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [15:0] m_data;
  logic        m_err;
  logic        bs_enable;
  logic        bs_write;
  logic [1:0]  bs_direction;
  logic [15:0] bs_input;
  logic [2:0]  bs_coeff;
  logic [15:0] bs_result;
  logic        busy;
  logic [15:0] txn_count;

  int checks = 0;
  int errors = 0;
  bs_rsp_t sb_q[$];
  logic force_ff = 1'b0;
  logic [15:0] peer_q;

  always #5 aclk = ~aclk;

  barrelshifter16_driver dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_amount(s_amount), .s_left(s_left),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err),
    .bs_enable(bs_enable), .bs_write(bs_write), .bs_direction(bs_direction),
    .bs_input(bs_input), .bs_coeff(bs_coeff), .bs_result(bs_result),
    .busy(busy), .txn_count(txn_count)
  );

  // Peer: shift register updates while enabled and not writing.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) peer_q <= '0;
    else if (bs_enable && !bs_write)
      peer_q <= (bs_direction == BS_DIR_LEFT) ? rotl16(bs_input, bs_coeff) : rotr16(bs_input, bs_coeff);
  end
  assign bs_result = force_ff ? 16'hFFFF : peer_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop one expected response per handshake.
  initial begin
    bs_rsp_t e;
    forever begin
      @(negedge aclk);
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got m_data=%h with empty scoreboard", m_data);
        end else begin
          e = sb_q.pop_front();
          chk("m_data", 32'(m_data), 32'(e.data));
          chk("m_err", 32'(m_err), 32'(e.err));
        end
      end
    end
  end

  task automatic send(input string nm, input logic [15:0] d, input logic [2:0] k, input logic left,
                      input logic [15:0] ed, input logic ee);
    int n;
    int wr;
    bs_rsp_t e;
    n = 0;
    while (s_ready !== 1'b1 && n < 50) begin
      @(posedge aclk); #1; n++;
    end
    chk({nm, " s_ready_wait"}, 32'(s_ready), 32'd1);
    s_data = d; s_amount = k; s_left = left; s_valid = 1'b1;
    e = {ed, ee};
    sb_q.push_back(e);
    @(posedge aclk); #1;
    s_valid = 1'b0;
    chk({nm, " bs_direction"}, 32'(bs_direction), left ? 32'd2 : 32'd1);
    chk({nm, " s_ready_low"}, 32'(s_ready), 32'd0);
    wr = 0;
    n = 0;
    while (m_valid !== 1'b1 && n < 20) begin
      if (bs_write === 1'b1) wr++;
      @(posedge aclk); #1; n++;
    end
    chk({nm, " latency"}, 32'(n), 32'd6);
    chk({nm, " write_cycles"}, 32'(wr), 32'd3);
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    #2;
    chk("rst s_ready", 32'(s_ready), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst m_valid", 32'(m_valid), 32'd0);
    chk("rst bs_enable", 32'(bs_enable), 32'd0);
    chk("rst txn_count", 32'(txn_count), 32'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [15:0] hold_d;
    logic saw_valid;
    #2 aresetn = 1'b0;
    #1;
    chk("rst0 s_ready", 32'(s_ready), 32'd1);
    chk("rst0 busy", 32'(busy), 32'd0);
    chk("rst0 bs_enable", 32'(bs_enable), 32'd0);
    chk("rst0 bs_write", 32'(bs_write), 32'd0);
    chk("rst0 outs", {bs_input, 11'd0, bs_coeff, bs_direction}, 32'd0);
    chk("rst0 m_resp", {m_data, 14'd0, m_valid, m_err}, 32'd0);
    chk("rst0 txn_count", 32'(txn_count), 32'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("idle bs_enable", 32'(bs_enable), 32'd0);
    chk("idle busy", 32'(busy), 32'd0);

    send("t2", 16'h8001, 3'd1, 1'b1, 16'h0003, 1'b0);
    send("t3", 16'h1234, 3'd4, 1'b0, 16'h4123, 1'b0);
    send("t4", 16'hA5A5, 3'd0, 1'b1, 16'hA5A5, 1'b0);
    send("t4b", 16'h8000, 3'd7, 1'b1, 16'h0040, 1'b0);
    @(posedge aclk); #1;
    chk("txn_count4", 32'(txn_count), 32'd4);

    do_reset();
    m_ready = 1'b0;
    send("t5a", 16'h00F0, 3'd4, 1'b1, 16'h0F00, 1'b0);
    hold_d = m_data;
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk); #1;
      chk("hold m_valid", 32'(m_valid), 32'd1);
      chk("hold m_data", 32'(m_data), 32'(hold_d));
      chk("hold s_ready", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    send("t5b", 16'h0F00, 3'd7, 1'b0, 16'h001E, 1'b0);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    chk("txn_count2", 32'(txn_count), 32'd2);

    do_reset();
    s_data = 16'h1111; s_amount = 3'd2; s_left = 1'b1; s_valid = 1'b1;
    @(posedge aclk); #1;
    s_valid = 1'b0;
    repeat (3) begin @(posedge aclk); #1; end
    chk("exec bs_enable", 32'(bs_enable), 32'd1);
    chk("exec bs_write", 32'(bs_write), 32'd0);
    aresetn = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst s_ready", 32'(s_ready), 32'd1);
    chk("midrst bs_enable", 32'(bs_enable), 32'd0);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk); #1;
      if (m_valid === 1'b1) saw_valid = 1'b1;
    end
    chk("midrst no_rsp", 32'(saw_valid), 32'd0);

    force_ff = 1'b1;
    send("t6", 16'h0001, 3'd1, 1'b1, 16'hFFFF, 1'b1);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    force_ff = 1'b0;
    chk("txn_count1", 32'(txn_count), 32'd1);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
